// File: rtl/detect_pkg.sv
// Shared definitions for the detection counter/display stage: segment patterns,
// dp FSM states and default parameter values.
package detect_pkg;

   localparam int MOD_DEFAULT     = 10;
   localparam int DP_HOLD_DEFAULT = 4;

   // Segment order is {g,f,e,d,c,b,a}, active-high
   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;

   typedef enum logic {DP_OFF, DP_ON} dp_state_e;

endpackage

// File: rtl/detect_count_display_if.sv
// Bus between the sequence detector side and the count/display stage.
interface detect_count_display_if;

   logic       det_in;
   logic       clr;
   logic [3:0] count;
   logic       wrap;
   logic [7:0] seg;

   modport master (output det_in, clr, input count, wrap, seg);
   modport slave  (input det_in, clr, output count, wrap, seg);

endinterface

// File: rtl/seg7_digit_decoder.sv
// Combinational 4-bit value to 7-segment {g..a} decoder; non-decimal values show a dash.
module seg7_digit_decoder
   import detect_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] segs
);

   always_comb begin
      segs = SEG_DASH;
      case (value)
         4'd0:    segs = SEG_0;
         4'd1:    segs = SEG_1;
         4'd2:    segs = SEG_2;
         4'd3:    segs = SEG_3;
         4'd4:    segs = SEG_4;
         4'd5:    segs = SEG_5;
         4'd6:    segs = SEG_6;
         4'd7:    segs = SEG_7;
         4'd8:    segs = SEG_8;
         4'd9:    segs = SEG_9;
         default: segs = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/detect_count_display.sv
// Counts rising edges of the detector match flag modulo MOD, shows the count on a
// 7-segment display and lights the decimal point for DP_HOLD cycles per detection.
module detect_count_display
   import detect_pkg::*;
#(
   parameter int MOD     = MOD_DEFAULT,
   parameter int DP_HOLD = DP_HOLD_DEFAULT
)(
   input  logic                  clk,
   input  logic                  reset,
   detect_count_display_if.slave bus
);

   localparam int                   TIMER_W = (DP_HOLD > 0) ? $clog2(DP_HOLD + 1) : 1;
   localparam logic [3:0]           LAST    = 4'(MOD - 1);
   localparam logic [TIMER_W-1:0]   HOLD    = TIMER_W'(DP_HOLD);

   logic               det_q;
   logic               rise;
   logic [3:0]         count;
   logic               wrap;
   logic [7:0]         seg;
   logic [6:0]         digit;
   logic [TIMER_W-1:0] timer;
   logic [TIMER_W-1:0] timer_next;
   dp_state_e          state;
   dp_state_e          state_next;

   // det_q resets high so a level already present at reset release is not a detection
   assign rise = bus.det_in & ~det_q;

   seg7_digit_decoder u_decoder (
      .value (count),
      .segs  (digit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         det_q <= 1'b1;
         count <= '0;
         wrap  <= 1'b0;
         seg   <= {1'b0, SEG_0};
      end else begin
         det_q <= bus.det_in;
         if (bus.clr) begin
            count <= '0;
            wrap  <= 1'b0;
         end else if (rise) begin
            wrap  <= (count == LAST);
            count <= (count == LAST) ? 4'd0 : count + 4'd1;
         end else begin
            wrap  <= 1'b0;
         end
         // Display follows the registered count/timer, one cycle behind them
         seg <= {timer != '0, digit};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= DP_OFF;
         timer <= '0;
      end else begin
         state <= state_next;
         timer <= timer_next;
      end
   end

   always_comb begin
      state_next = state;
      timer_next = timer;
      if (bus.clr) begin
         state_next = DP_OFF;
         timer_next = '0;
      end else if (rise) begin
         // A rise while already lit simply restarts the hold
         timer_next = HOLD;
         state_next = (DP_HOLD > 0) ? DP_ON : DP_OFF;
      end else if (state == DP_ON) begin
         timer_next = timer - TIMER_W'(1);
         if (timer == TIMER_W'(1)) begin
            state_next = DP_OFF;
         end
      end
   end

   assign bus.count = count;
   assign bus.wrap  = wrap;
   assign bus.seg   = seg;

endmodule

// File: tb/tb_detect_count_display.sv
// Directed bench for detect_count_display: a cycle model built from the counting and
// display rules is compared every cycle, plus hand-computed checkpoints.
module tb_detect_count_display;

   localparam int MOD     = 10;
   localparam int DP_HOLD = 4;
   localparam int NEVER   = 1000;

   logic clk;
   logic reset;

   detect_count_display_if bus ();

   detect_count_display #(.MOD(MOD), .DP_HOLD(DP_HOLD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: count of accepted detections, and age in edges since the last accepted one
   logic [7:0] pat [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                             8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
   logic       m_valid = 1'b0;
   logic       m_prev;
   int         m_count;
   logic       m_wrap;
   logic [7:0] m_seg;
   int         m_age;

   always @(posedge clk) begin
      if (reset) begin
         m_valid = 1'b1;
         m_prev  = 1'b1;
         m_count = 0;
         m_wrap  = 1'b0;
         m_seg   = 8'h3F;
         m_age   = NEVER;
      end else if (m_valid) begin
         m_seg = {(m_age < DP_HOLD), 7'(pat[m_count])};
         if (bus.clr) begin
            m_count = 0;
            m_wrap  = 1'b0;
            m_age   = NEVER;
         end else if (bus.det_in && !m_prev) begin
            m_wrap  = (m_count == MOD - 1);
            m_count = (m_count + 1) % MOD;
            m_age   = 0;
         end else begin
            m_wrap = 1'b0;
            if (m_age < NEVER) m_age++;
         end
         m_prev = bus.det_in;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_count", {4'h0, bus.count}, 8'(m_count));
         check("model_wrap",  {7'h0, bus.wrap},  {7'h0, m_wrap});
         check("model_seg",   bus.seg,           m_seg);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int gap);
      bus.det_in = 1'b1;
      tick();
      bus.det_in = 1'b0;
      repeat (gap - 1) tick();
   endtask

   initial begin
      reset      = 1'b1;
      bus.det_in = 1'b1;
      bus.clr    = 1'b0;

      // 1: level held through reset is not counted
      tick(); tick();
      reset = 1'b0;
      check("rst_count", {4'h0, bus.count}, 8'd0);
      check("rst_wrap",  {7'h0, bus.wrap},  8'd0);
      check("rst_seg",   bus.seg,           8'h3F);
      repeat (3) tick();
      check("held_count", {4'h0, bus.count}, 8'd0);
      check("held_seg",   bus.seg,           8'h3F);
      bus.det_in = 1'b0;
      tick();

      // 2: three pulses spaced 6 cycles
      pulse(6);
      pulse(6);
      bus.det_in = 1'b1;
      tick();
      bus.det_in = 1'b0;
      check("p3_count", {4'h0, bus.count}, 8'd3);
      tick();
      check("p3_seg_dp", bus.seg, 8'hCF);
      repeat (3) tick();
      check("p3_seg_dp_last", bus.seg, 8'hCF);
      tick();
      check("p3_seg_off", bus.seg, 8'h4F);

      // 3: five-cycle level counts once
      bus.det_in = 1'b1;
      repeat (5) tick();
      bus.det_in = 1'b0;
      tick();
      check("level_count", {4'h0, bus.count}, 8'd4);

      // 4: ten pulses from zero wrap on the tenth
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      check("clr_count", {4'h0, bus.count}, 8'd0);
      repeat (9) pulse(3);
      check("nine_count", {4'h0, bus.count}, 8'd9);
      bus.det_in = 1'b1;
      tick();
      bus.det_in = 1'b0;
      check("wrap_count", {4'h0, bus.count}, 8'd0);
      check("wrap_pulse", {7'h0, bus.wrap},  8'd1);
      tick();
      check("wrap_drop", {7'h0, bus.wrap}, 8'd0);
      check("wrap_seg",  bus.seg,          8'hBF);
      repeat (4) tick();

      // 5: clr beats a simultaneous rise
      repeat (5) pulse(6);
      check("five_count", {4'h0, bus.count}, 8'd5);
      check("five_seg",   bus.seg,           8'h6D);
      bus.clr    = 1'b1;
      bus.det_in = 1'b1;
      tick();
      bus.clr    = 1'b0;
      bus.det_in = 1'b0;
      check("clrrise_count", {4'h0, bus.count}, 8'd0);
      check("clrrise_wrap",  {7'h0, bus.wrap},  8'd0);
      tick();
      check("clrrise_seg", bus.seg, 8'h3F);
      tick();
      check("clrrise_seg2", bus.seg, 8'h3F);

      // 6: retriggered hold, then drop exactly DP_HOLD cycles after the last update
      repeat (4) pulse(2);
      check("retrig_seg_first", bus.seg, 8'hE6);
      repeat (3) tick();
      check("retrig_seg_last", bus.seg, 8'hE6);
      tick();
      check("retrig_seg_off", bus.seg, 8'h66);

      // reset in the middle of a hold
      pulse(2);
      check("hold_seg", bus.seg, 8'hED);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_seg",   bus.seg,           8'h3F);
      check("midrst_count", {4'h0, bus.count}, 8'd0);
      tick();
      check("midrst_seg2", bus.seg, 8'h3F);
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
